// File: rtl/divider_unit_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// iteration counter width and FSM state encodings.
package divider_unit_pkg;
  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_ITER,
    S_CORR,
    S_FIX,
    S_DONE
  } div_state_e;
endpackage

// File: rtl/div_addsub.sv
// W-bit adder/subtractor: sum = a + (b ^ {W{sub}}) + sub; carry-out is dropped.
module div_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);
  assign sum_o = a_i + (b_i ^ {W{sub_i}}) + W'(sub_i);
endmodule

// File: rtl/divider_unit.sv
// Sequential signed non-restoring divider, one quotient bit per cycle.
// Quotient truncates toward zero; remainder follows the dividend's sign.
module divider_unit
  import divider_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e state_q, state_d;
  logic [AW-1:0]    a_q, m_q;
  logic [WIDTH-1:0] q_q, quot_q, rem_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_dd_q, sign_dv_q, dbz_pend_q, ovf_pend_q, dbz_q, ovf_q;

  logic [AW-1:0] add0_a, add0_b, add0_sum, add1_b, add1_sum, shifted;
  logic          add0_sub;

  assign shifted = {a_q[WIDTH-1:0], q_q[WIDTH-1]};

  // Adder 0 carries the main datapath; adder 1 is a negator for M (ABS) and A (FIX).
  always_comb begin
    add0_a   = '0;
    add0_b   = '0;
    add0_sub = 1'b0;
    add1_b   = '0;
    unique case (state_q)
      S_ABS: begin
        add0_b   = {q_q[WIDTH-1], q_q};
        add0_sub = 1'b1;
        add1_b   = m_q;
      end
      S_ITER: begin
        add0_a   = shifted;
        add0_b   = m_q;
        add0_sub = ~a_q[WIDTH];
      end
      S_CORR: begin
        add0_a = a_q;
        add0_b = m_q;
      end
      S_FIX: begin
        add0_b   = {1'b0, q_q};
        add0_sub = 1'b1;
        add1_b   = a_q;
      end
      default: ;
    endcase
  end

  div_addsub #(.W(AW)) u_add0 (
    .a_i(add0_a), .b_i(add0_b), .sub_i(add0_sub), .sum_o(add0_sum)
  );

  div_addsub #(.W(AW)) u_add1 (
    .a_i('0), .b_i(add1_b), .sub_i(1'b1), .sum_o(add1_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_ABS;
      S_ABS: begin
        busy    = 1'b1;
        state_d = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_CORR;
      end
      S_CORR: begin
        busy    = 1'b1;
        state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      m_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      sign_dd_q  <= 1'b0;
      sign_dv_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          q_q        <= dividend;
          m_q        <= {divisor[WIDTH-1], divisor};
          sign_dd_q  <= dividend[WIDTH-1];
          sign_dv_q  <= divisor[WIDTH-1];
          dbz_pend_q <= (divisor == '0);
          ovf_pend_q <= (dividend == MIN_VAL) && (divisor == '1);
          dbz_q      <= 1'b0;
          ovf_q      <= 1'b0;
        end
        S_ABS: begin
          if (sign_dd_q) q_q <= add0_sum[WIDTH-1:0];
          if (sign_dv_q) m_q <= add1_sum;
          a_q   <= '0;
          cnt_q <= '0;
        end
        S_ITER: begin
          a_q   <= add0_sum;
          q_q   <= {q_q[WIDTH-2:0], ~add0_sum[WIDTH]};
          cnt_q <= cnt_q + CW'(1);
        end
        S_CORR: if (a_q[WIDTH]) a_q <= add0_sum;
        S_FIX: begin
          // With a zero divisor every quotient bit is set and A ends as |dividend|,
          // so only the quotient needs overriding.
          if (dbz_pend_q)                 quot_q <= '1;
          else if (sign_dd_q ^ sign_dv_q) quot_q <= add0_sum[WIDTH-1:0];
          else                            quot_q <= q_q;
          rem_q <= sign_dd_q ? add1_sum[WIDTH-1:0] : a_q[WIDTH-1:0];
          dbz_q <= dbz_pend_q;
          ovf_q <= ovf_pend_q;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: directed vectors push expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_divider_unit;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 3;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int unsigned  acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero, overflow;
  logic [W-1:0] quotient, remainder;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned edge_cnt = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  divider_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no result pending (q=0x%08h)", quotient);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("div_by_zero", W'(div_by_zero), W'(mon_e.dbz));
        check("overflow", W'(overflow), W'(mon_e.ovf));
        check("latency", W'(edge_cnt - mon_e.acc), W'(LAT));
        check("busy_at_done", W'(busy), '0);
      end
    end
  end

  task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic dbz, input logic ovf, input bit track);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    if (track) begin
      e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.acc = edge_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_dbz", W'(div_by_zero), '0);
    check("rst_ovf", W'(overflow), '0);

    issue(32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b0, 1'b1);                 drain();
    issue(-32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1); drain();
    issue(32'd7, -32'sd2, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 1'b1);        drain();
    issue(-32'sd7, -32'sd2, 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);      drain();
    issue(32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1'b1, 1'b0, 1'b1);      drain();
    issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1, 1'b1); drain();
    issue(32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 1'b0, 1'b1);                drain();

    // Second start mid-operation must be ignored; busy stays high until DONE.
    issue(32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      if (k == 10) begin
        start = 1'b1; dividend = 32'd5; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
      check("busy_in_flight", W'(busy), W'(1));
    end
    start = 1'b0;
    drain();

    // Reset in the middle of an operation: no result appears, outputs clear.
    issue(32'd12345, 32'd11, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", W'(busy), '0);
    check("midrst_done", W'(done), '0);
    check("midrst_quotient", quotient, '0);
    check("midrst_remainder", remainder, '0);
    check("midrst_dbz", W'(div_by_zero), '0);
    check("midrst_ovf", W'(overflow), '0);
    repeat (40) @(posedge clk);

    issue(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b0, 1'b1); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
